// File: rtl/codificador_prio_reg_if.sv
// Output handshake bundle of the registered priority encoder: encoded index
// with valid/ready flow control.
interface codificador_prio_reg_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  logic         out_valid;
  logic [W-1:0] out_idx;
  logic         out_ready;

  modport master (
    output out_valid,
    output out_idx,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_idx,
    output out_ready
  );
endinterface

// File: rtl/codificador_prio_reg.sv
// Registered N-input priority encoder: latches requests into sticky pending
// bits and hands out one index per valid/ready transfer. Define
// CODIFICADOR_RR_EN for round-robin selection instead of fixed highest-index.
module codificador_prio_reg #(
  parameter int N = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req,
  codificador_prio_reg_if.master out_if,
  output logic                   busy
);
  localparam int W = $clog2(N);

  logic [N-1:0] pending_q, pending_d;
  logic         valid_q, valid_d;
  logic [W-1:0] idx_q, idx_d;
  logic         slot_free;
  logic         load;
  logic [W-1:0] sel_idx;
  logic [N-1:0] grant_mask;

`ifdef CODIFICADOR_RR_EN
  logic [W-1:0] ptr_q, ptr_d;

  // Scan downward from p_ptr, wrapping from 0 back to N-1.
  function automatic logic [W-1:0] sel_rr(input logic [N-1:0] p,
                                          input logic [W-1:0] p_ptr);
    logic [W-1:0] s;
    logic         found;
    int           j;
    s     = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(p_ptr) - k;
      if (j < 0) j = j + N;
      if (!found && p[j]) begin
        s     = W'(j);
        found = 1'b1;
      end
    end
    return s;
  endfunction
`else
  function automatic logic [W-1:0] sel_fixed(input logic [N-1:0] p);
    logic [W-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) begin
      if (p[i]) s = W'(i);
    end
    return s;
  endfunction
`endif

  always_comb begin
    slot_free = !valid_q || out_if.out_ready;
    load      = slot_free && (|pending_q);
`ifdef CODIFICADOR_RR_EN
    sel_idx   = sel_rr(pending_q, ptr_q);
`else
    sel_idx   = sel_fixed(pending_q);
`endif
    grant_mask = '0;
    if (load) grant_mask = {{(N-1){1'b0}}, 1'b1} << sel_idx;

    // A request arriving on the granted bit in the same edge survives the clear.
    pending_d = (pending_q & ~grant_mask) | req;

    valid_d = valid_q;
    idx_d   = idx_q;
    if (slot_free) valid_d = load;
    if (load)      idx_d   = sel_idx;
  end

`ifdef CODIFICADOR_RR_EN
  always_comb begin
    ptr_d = ptr_q;
    if (load) ptr_d = (sel_idx == '0) ? W'(N - 1) : (sel_idx - 1'b1);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= W'(N - 1);
    else     ptr_q <= ptr_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
    end else begin
      pending_q <= pending_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
    end
  end

  assign out_if.out_valid = valid_q;
  assign out_if.out_idx   = idx_q;
  assign busy             = |pending_q;
endmodule

// File: tb/tb_codificador_prio_reg.sv
// Directed bench for codificador_prio_reg (N=8), fixed-priority and
// round-robin builds.
module tb_codificador_prio_reg;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic         busy;
  int           n_cmp = 0;
  int           n_bad = 0;

  codificador_prio_reg_if #(.N(N)) oif ();

  codificador_prio_reg #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .out_if (oif.master),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    oif.out_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Expect a valid index after the next edge.
  task automatic expect_idx(input string tag, input int idx);
    tick();
    check_val({tag, "_v"}, int'(oif.out_valid), 1);
    check_val({tag, "_idx"}, int'(oif.out_idx), idx);
  endtask

  int seq3 [4] = '{7, 5, 2, 0};
  int seq4 [2];
  int seq6 [4];

  initial begin
`ifdef CODIFICADOR_RR_EN
    seq4 = '{1, 7};
    seq6 = '{7, 0, 7, 0};
`else
    seq4 = '{7, 1};
    seq6 = '{7, 7, 7, 7};
`endif
    oif.out_ready = 1'b1;

    // Reset holds everything low even with all requests high.
    rst = 1'b1;
    req = 8'hFF;
    for (int c = 0; c < 2; c++) begin
      tick();
      check_val("rst_v", int'(oif.out_valid), 0);
      check_val("rst_idx", int'(oif.out_idx), 0);
      check_val("rst_busy", int'(busy), 0);
    end
    rst = 1'b0;
    req = '0;
    for (int c = 0; c < 6; c++) begin
      tick();
      check_val("idle_v", int'(oif.out_valid), 0);
      check_val("idle_busy", int'(busy), 0);
    end

    // Single pulse: two-edge latency.
    do_reset();
    req = 8'h08;
    tick();
    req = '0;
    check_val("pulse_busy_k", int'(busy), 1);
    check_val("pulse_v_k", int'(oif.out_valid), 0);
    expect_idx("pulse_k1", 3);
    tick();
    check_val("pulse_v_k2", int'(oif.out_valid), 0);
    check_val("pulse_busy_k2", int'(busy), 0);

    // Back-to-back drain of several requests.
    do_reset();
    req = 8'hA5;
    tick();
    req = '0;
    for (int i = 0; i < 4; i++) expect_idx("a5", seq3[i]);
    tick();
    check_val("a5_end_v", int'(oif.out_valid), 0);
    check_val("a5_end_busy", int'(busy), 0);

    // Stall with a new request arriving mid-stall.
    do_reset();
    oif.out_ready = 1'b0;
    req = 8'h06;
    tick();
    req = '0;
    expect_idx("stall_first", 2);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) req = 8'h80;
      tick();
      req = '0;
      check_val("stall_v", int'(oif.out_valid), 1);
      check_val("stall_idx", int'(oif.out_idx), 2);
      check_val("stall_busy", int'(busy), 1);
    end
    oif.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) expect_idx("stall_drain", seq4[i]);
    tick();
    check_val("stall_end_v", int'(oif.out_valid), 0);

    // Re-request on the bit being granted in the same edge.
    do_reset();
    req = 8'h10;
    tick();
    expect_idx("rereq_a", 4);
    req = '0;
    expect_idx("rereq_b", 4);
    tick();
    check_val("rereq_end_v", int'(oif.out_valid), 0);

    // Two sources held high continuously.
    do_reset();
    req = 8'h81;
    tick();
    for (int i = 0; i < 4; i++) expect_idx("hold81", seq6[i]);
    req = '0;

    // Reset mid-transfer discards held index and pending bits.
    oif.out_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("midrst_v", int'(oif.out_valid), 0);
    check_val("midrst_idx", int'(oif.out_idx), 0);
    check_val("midrst_busy", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
